// File: rtl/combo_lock_ctrl.sv
// N-digit combination lock sequencer: edge-detected ENTER/GO/RESTART, BCD entry
// countdown, failed-attempt counting and timed lockout for the display/LED path.
//   state   | meaning
//   IDLE    | waiting for GO
//   ENTER   | collecting digits, entry countdown running
//   CHECK   | one-cycle verdict on the collected digits
//   OPEN    | correct code, held until RESTART
//   FAIL    | wrong code or timeout, held until RESTART
//   LOCKOUT | too many failures, all edges ignored until the timer expires
module combo_lock_ctrl #(
  parameter int                    NUM_DIGITS   = 4,
  parameter logic [4*NUM_DIGITS-1:0] COMBO      = 16'h1357,
  parameter int                    MAX_TRIES    = 3,
  parameter int                    ENTRY_SECS   = 30,
  parameter int                    LOCKOUT_SECS = 10
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       tick,
  input  logic [3:0] digit_in,
  input  logic       ent,
  input  logic       go,
  input  logic       restart,
  output logic [5:0] state_led,
  output logic       unlocked,
  output logic       locked_out,
  output logic [2:0] digit_idx,
  output logic [3:0] tries_left,
  output logic [7:0] timer_bcd
);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_ENTER = 6'b000010,
    S_CHECK = 6'b000100,
    S_OPEN  = 6'b001000,
    S_FAIL  = 6'b010000,
    S_LOCK  = 6'b100000
  } state_t;

  localparam logic [7:0] ENTRY_BCD = {4'(ENTRY_SECS / 10), 4'(ENTRY_SECS % 10)};
  localparam logic [7:0] LOCK_BCD  = {4'(LOCKOUT_SECS / 10), 4'(LOCKOUT_SECS % 10)};
  localparam logic [3:0] MAX_T     = 4'(MAX_TRIES);
  localparam logic [2:0] LAST_IDX  = 3'(NUM_DIGITS - 1);

  state_t              r_state;
  logic                r_ent_q, r_go_q, r_rst_q;
  logic                r_mis;
  logic [2:0]          r_idx;
  logic [3:0]          r_tries;
  logic [7:0]          r_timer;

  logic                w_ent_e, w_go_e, w_rst_e;
  logic [2:0]          w_pos;
  logic [4*NUM_DIGITS-1:0] w_shift;
  logic [3:0]          w_exp;
  logic                w_bad;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)            return 8'h00;
    else if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    else                       return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign w_ent_e = ent & ~r_ent_q;
  assign w_go_e  = go & ~r_go_q;
  assign w_rst_e = restart & ~r_rst_q;

  // Digits are entered most-significant first, so index 0 sits at the top of COMBO.
  assign w_pos   = LAST_IDX - r_idx;
  assign w_shift = COMBO >> {w_pos, 2'b00};
  assign w_exp   = w_shift[3:0];
  assign w_bad   = (digit_in != w_exp) || (digit_in > 4'd9);

  assign state_led  = r_state;
  assign unlocked   = (r_state == S_OPEN);
  assign locked_out = (r_state == S_LOCK);
  assign digit_idx  = r_idx;
  assign tries_left = r_tries;
  assign timer_bcd  = r_timer;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_ent_q <= 1'b1;
      r_go_q  <= 1'b1;
      r_rst_q <= 1'b1;
      r_mis   <= 1'b0;
      r_idx   <= 3'd0;
      r_tries <= MAX_T;
      r_timer <= 8'h00;
    end else begin
      r_ent_q <= ent;
      r_go_q  <= go;
      r_rst_q <= restart;
      case (r_state)
        S_IDLE: begin
          if (w_go_e) begin
            r_state <= S_ENTER;
            r_idx   <= 3'd0;
            r_mis   <= 1'b0;
            r_timer <= ENTRY_BCD;
          end
        end
        S_ENTER: begin
          if (w_rst_e) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
          end else begin
            if (w_ent_e) begin
              r_mis <= r_mis | w_bad;
              if (r_idx == LAST_IDX) r_state <= S_CHECK;
              else                   r_idx   <= r_idx + 3'd1;
            end
            if (tick) begin
              r_timer <= bcd_dec(r_timer);
              // Window expiry with no digit this cycle: fail immediately, skipping CHECK.
              if (!w_ent_e && r_timer == 8'h01) begin
                r_mis <= 1'b1;
                if (r_tries <= 4'd1) begin
                  r_tries <= 4'd0;
                  r_state <= S_LOCK;
                  r_timer <= LOCK_BCD;
                end else begin
                  r_tries <= r_tries - 4'd1;
                  r_state <= S_FAIL;
                end
              end
            end
          end
        end
        S_CHECK: begin
          if (!r_mis) begin
            r_state <= S_OPEN;
            r_tries <= MAX_T;
          end else if (r_tries <= 4'd1) begin
            r_tries <= 4'd0;
            r_state <= S_LOCK;
            r_timer <= LOCK_BCD;
          end else begin
            r_tries <= r_tries - 4'd1;
            r_state <= S_FAIL;
          end
        end
        S_OPEN, S_FAIL: begin
          if (w_rst_e) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
          end
        end
        S_LOCK: begin
          if (tick) begin
            if (r_timer == 8'h01) begin
              r_timer <= 8'h00;
              r_tries <= MAX_T;
              r_state <= S_IDLE;
              r_idx   <= 3'd0;
            end else begin
              r_timer <= bcd_dec(r_timer);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Scoreboard bench for combo_lock_ctrl: a queue/integer reference model predicts
// every cycle's outputs; directed test-plan sequences are followed by random traffic.
module tb_combo_lock_ctrl;
  localparam int          N     = 4;
  localparam logic [15:0] CMB   = 16'h1357;
  localparam int          MAXT  = 3;
  localparam int          ENT_S = 30;
  localparam int          LCK_S = 10;

  logic       clk = 1'b0;
  logic       RST_n = 1'b0;
  logic       tick = 1'b0, ent = 1'b0, go = 1'b0, restart = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic [5:0] state_led;
  logic       unlocked, locked_out;
  logic [2:0] digit_idx;
  logic [3:0] tries_left;
  logic [7:0] timer_bcd;

  logic       d2_tick = 1'b0, d2_ent = 1'b0, d2_go = 1'b0, d2_restart = 1'b0;
  logic [3:0] d2_digit = 4'd0;
  logic [5:0] d2_state;
  logic       d2_unlocked, d2_locked;
  logic [2:0] d2_idx;
  logic [3:0] d2_tries;
  logic [7:0] d2_timer;

  always #5 clk = ~clk;

  combo_lock_ctrl #(.NUM_DIGITS(N), .COMBO(CMB), .MAX_TRIES(MAXT),
                    .ENTRY_SECS(ENT_S), .LOCKOUT_SECS(LCK_S)) dut (
    .clk(clk), .RST_n(RST_n), .tick(tick), .digit_in(digit_in), .ent(ent),
    .go(go), .restart(restart), .state_led(state_led), .unlocked(unlocked),
    .locked_out(locked_out), .digit_idx(digit_idx), .tries_left(tries_left),
    .timer_bcd(timer_bcd));

  combo_lock_ctrl #(.NUM_DIGITS(1), .COMBO(4'h9)) dut2 (
    .clk(clk), .RST_n(RST_n), .tick(d2_tick), .digit_in(d2_digit), .ent(d2_ent),
    .go(d2_go), .restart(d2_restart), .state_led(d2_state), .unlocked(d2_unlocked),
    .locked_out(d2_locked), .digit_idx(d2_idx), .tries_left(d2_tries),
    .timer_bcd(d2_timer));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int tag; logic [22:0] exp; } item_t;
  item_t sb_q[$];

  // Reference model: modes 0..5 follow the state_led bit positions.
  int m_mode, m_tries, m_timer;
  int m_ent[$];
  bit pe, pg, pr;
  bit rst_drv = 1'b0;
  int combo_dig[N];

  function automatic int to_bcd(int v);
    return (v / 10) * 16 + v % 10;
  endfunction

  function automatic logic [22:0] m_expect();
    int idx;
    idx = (m_ent.size() < N - 1) ? m_ent.size() : N - 1;
    return {6'(1 << m_mode), (m_mode == 3), (m_mode == 5), 3'(idx), 4'(m_tries),
            8'(to_bcd(m_timer))};
  endfunction

  task automatic m_reset();
    m_mode = 0; m_tries = MAXT; m_timer = 0; m_ent.delete();
    pe = 1; pg = 1; pr = 1;
  endtask

  task automatic m_fail();
    m_tries = (m_tries > 0) ? m_tries - 1 : 0;
    if (m_tries == 0) begin m_mode = 5; m_timer = LCK_S; end
    else m_mode = 4;
  endtask

  task automatic m_step(bit tk, int d, bit e, bit g, bit r);
    bit ee, ge, re, ok;
    ee = e && !pe; ge = g && !pg; re = r && !pr;
    case (m_mode)
      0: if (ge) begin m_mode = 1; m_ent.delete(); m_timer = ENT_S; end
      1: begin
        if (re) begin
          m_mode = 0; m_ent.delete();
        end else begin
          if (ee) begin
            m_ent.push_back(d);
            if (m_ent.size() == N) m_mode = 2;
          end
          if (tk) begin
            if (!ee && m_timer == 1) begin m_timer = 0; m_fail(); end
            else if (m_timer > 0) m_timer--;
          end
        end
      end
      2: begin
        ok = 1;
        for (int i = 0; i < N; i++)
          if (m_ent[i] != combo_dig[i] || m_ent[i] > 9) ok = 0;
        if (ok) begin m_mode = 3; m_tries = MAXT; end
        else m_fail();
      end
      3, 4: if (re) begin m_mode = 0; m_ent.delete(); end
      5: if (tk) begin
        if (m_timer == 1) begin m_timer = 0; m_tries = MAXT; m_mode = 0; m_ent.delete(); end
        else if (m_timer > 0) m_timer--;
      end
      default: m_mode = 0;
    endcase
    pe = e; pg = g; pr = r;
  endtask

  task automatic cyc1(bit tk, int d, bit e, bit g, bit r);
    item_t it;
    tick = tk; digit_in = 4'(d); ent = e; go = g; restart = r; RST_n = rst_drv;
    if (!rst_drv) m_reset();
    else m_step(tk, d, e, g, r);
    it.tag = cyc + 1;
    it.exp = m_expect();
    sb_q.push_back(it);
    @(posedge clk); #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();             cyc1(0, 0, 0, 0, 0); endtask
  task automatic pulse_go();         cyc1(0, 0, 0, 1, 0); idle(); endtask
  task automatic pulse_restart();    cyc1(0, 0, 0, 0, 1); idle(); endtask
  task automatic ent_digit(int d);   cyc1(0, d, 1, 0, 0); cyc1(0, d, 0, 0, 0); endtask

  always @(negedge clk) begin
    item_t it;
    logic [22:0] act;
    while (sb_q.size() > 0 && sb_q[0].tag <= cyc) begin
      it = sb_q.pop_front();
      act = {state_led, unlocked, locked_out, digit_idx, tries_left, timer_bcd};
      n_cmp++;
      if (act !== it.exp) begin
        n_bad++;
        $display("FAIL scoreboard cyc=%0d: got %h expected %h", it.tag, act, it.exp);
      end
    end
  end

  initial begin
    item_t it;
    int d;
    bit tk, e, g, r;
    for (int i = 0; i < N; i++) combo_dig[i] = int'((CMB >> (4 * (N - 1 - i))) & 16'hF);

    // Power-on reset
    rst_drv = 0; idle(); idle();
    check("reset_state", 32'(state_led), 32'h01);
    check("reset_tries", 32'(tries_left), 32'(MAXT));
    check("reset_timer", 32'(timer_bcd), 32'h00);
    rst_drv = 1; idle();

    // Correct code
    pulse_go();
    check("go_timer_load", 32'(timer_bcd), 32'h30);
    ent_digit(1); ent_digit(3); ent_digit(5);
    cyc1(0, 7, 1, 0, 0);
    check("check_state", 32'(state_led), 32'h04);
    cyc1(0, 7, 0, 0, 0);
    check("open_state", 32'(state_led), 32'h08);
    check("open_unlocked", 32'(unlocked), 32'h1);
    check("open_tries", 32'(tries_left), 32'(MAXT));
    pulse_restart();
    check("restart_idle", 32'(state_led), 32'h01);

    // Three wrong codes into lockout
    for (int k = 1; k <= 3; k++) begin
      pulse_go();
      ent_digit(1); ent_digit(3); ent_digit(5); ent_digit(8);
      if (k < 3) begin
        check("fail_state", 32'(state_led), 32'h10);
        check("fail_tries", 32'(tries_left), 32'(MAXT - k));
        pulse_restart();
      end
    end
    check("lockout_flag", 32'(locked_out), 32'h1);
    check("lockout_timer", 32'(timer_bcd), 32'h10);

    // Lockout expiry with ignored edges
    for (int i = 1; i <= 10; i++) begin
      cyc1(0, 1, 1, 1, 1); idle();
      check("lock_hold", 32'(locked_out), 32'h1);
      check("lock_timer", 32'(timer_bcd), 32'(to_bcd(11 - i)));
      cyc1(1, 0, 0, 0, 0);
    end
    check("lock_exit_state", 32'(state_led), 32'h01);
    check("lock_exit_timer", 32'(timer_bcd), 32'h00);
    check("lock_exit_tries", 32'(tries_left), 32'(MAXT));

    // Entry timeout
    pulse_go();
    ent_digit(1); ent_digit(3);
    for (int k = 1; k <= 30; k++) begin
      cyc1(1, 0, 0, 0, 0);
      if (k == 1)  check("bcd_30_29", 32'(timer_bcd), 32'h29);
      if (k == 20) check("bcd_10", 32'(timer_bcd), 32'h10);
      if (k == 21) check("bcd_10_09", 32'(timer_bcd), 32'h09);
    end
    check("timeout_state", 32'(state_led), 32'h10);
    check("timeout_tries", 32'(tries_left), 32'h2);
    pulse_restart();

    // Last digit coinciding with the final tick
    pulse_go();
    ent_digit(1); ent_digit(3); ent_digit(5);
    repeat (29) cyc1(1, 0, 0, 0, 0);
    check("timer_at_01", 32'(timer_bcd), 32'h01);
    cyc1(1, 7, 1, 0, 0); idle();
    check("race_open", 32'(state_led), 32'h08);
    check("race_tries", 32'(tries_left), 32'(MAXT));
    pulse_restart();

    // restart with ent aborts without using a try
    pulse_go();
    ent_digit(1);
    cyc1(0, 3, 1, 0, 1); idle();
    check("abort_state", 32'(state_led), 32'h01);
    check("abort_tries", 32'(tries_left), 32'(MAXT));

    // Reset mid-entry with ent held high
    pulse_go();
    ent_digit(1); ent_digit(3);
    cyc1(0, 5, 1, 0, 0);
    @(negedge clk); #1;
    rst_drv = 0; RST_n = 1'b0; m_reset();
    #1;
    check("async_rst_state", 32'(state_led), 32'h01);
    check("async_rst_idx", 32'(digit_idx), 32'h0);
    it.tag = cyc + 1; it.exp = m_expect(); sb_q.push_back(it);
    cyc1(0, 5, 1, 0, 0);
    rst_drv = 1;
    cyc1(0, 5, 1, 0, 0); cyc1(0, 5, 1, 0, 0);
    cyc1(0, 5, 1, 1, 0); cyc1(0, 5, 1, 0, 0);
    check("held_ent_idx", 32'(digit_idx), 32'h0);
    check("held_ent_state", 32'(state_led), 32'h02);
    idle(); pulse_restart();

    // Single-digit instance
    d2_go = 1; idle(); d2_go = 0; idle();
    check("d1_enter", 32'(d2_state), 32'h02);
    d2_digit = 4'd9; d2_ent = 1; idle();
    check("d1_check", 32'(d2_state), 32'h04);
    d2_ent = 0; idle();
    check("d1_open", 32'(d2_state), 32'h08);
    check("d1_unlocked", 32'(d2_unlocked), 32'h1);

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      tk = ($urandom % 4) == 0;
      e  = $urandom % 2;
      g  = ($urandom % 6) == 0;
      r  = ($urandom % 50) == 0;
      if (($urandom % 4) != 0)
        d = combo_dig[(m_ent.size() < N) ? m_ent.size() : N - 1];
      else
        d = int'($urandom % 16);
      cyc1(tk, d, e, g, r);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/combo_lock_ctrl.md
# combo_lock_ctrl

Parametrised N-digit combination-lock controller that replaces the fixed two-digit lock sequencing in the final-lab driver. It sits between the debounced switch/keypad inputs and the display path. It takes BCD digit entries and accepts ENTER, GO and RESTART pulses. It enforces an entry countdown, counts failed attempts and applies a timed lockout after too many failures. Its BCD timer, attempt count and one-hot state outputs feed the existing 7-segment mux and LED path.

## Interface
- NUM_DIGITS, 4: digits in the combination, 1..8
- COMBO, 16'h1357: combination as packed BCD, 4*NUM_DIGITS bits, most-significant digit entered first
- MAX_TRIES, 3: failed attempts allowed before lockout, 1..15
- ENTRY_SECS, 30: entry window in ticks, 1..99
- LOCKOUT_SECS, 10: lockout duration in ticks, 1..99
- clk  in  1  system clock; all state changes on the rising edge
- RST_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle seconds strobe (1 Hz enable), synchronous to clk
- digit_in  in  4  BCD digit presented with ENTER; values above 9 never match
- ent  in  1  ENTER level input; acted on at its rising edge
- go  in  1  GO level input; acted on at its rising edge
- restart  in  1  RESTART level input; acted on at its rising edge
- state_led  out  6  one-hot state: [0] IDLE, [1] ENTER, [2] CHECK, [3] OPEN, [4] FAIL, [5] LOCKOUT
- unlocked  out  1  high in OPEN
- locked_out  out  1  high in LOCKOUT
- digit_idx  out  3  index of the next digit expected, 0-based
- tries_left  out  4  remaining attempts
- timer_bcd  out  8  countdown as two BCD digits {tens, ones}

## Operation
- Edge detect: each of ent/go/restart has a previous-value register, reset to 1, so a switch held high through reset produces no edge. Edge = input & ~prev.
- Reset values: state IDLE (state_led=6'b000001), unlocked=0, locked_out=0, digit_idx=0, tries_left=MAX_TRIES, timer_bcd=8'h00, mismatch flag=0.
- IDLE: a go edge moves to ENTER with digit_idx=0, mismatch=0 and timer_bcd loaded with ENTRY_SECS in BCD.
- ENTER:
  - An ent edge compares digit_in with COMBO digit[digit_idx] and ORs any mismatch into the sticky flag.
  - If digit_idx==NUM_DIGITS-1, the next state is CHECK; otherwise digit_idx increments.
  - A tick decrements timer_bcd as BCD (ones wraps 0→9 with tens borrow).
  - If timer_bcd is 8'h01 and a tick arrives with no ent edge, the attempt counts as a failure and proceeds as in CHECK with mismatch forced to 1.
- CHECK: one cycle.
  - mismatch=0 → OPEN, tries_left=MAX_TRIES.
  - Otherwise tries_left decrements. If the result is 0 → LOCKOUT with timer_bcd=LOCKOUT_SECS; else → FAIL.
- OPEN / FAIL: hold until a restart edge, then → IDLE. timer_bcd is frozen; digit_idx returns to 0 on leaving the state.
- LOCKOUT:
  - All edges are ignored, including restart. tick decrements timer_bcd.
  - A tick at 8'h01 sets timer_bcd=8'h00, tries_left=MAX_TRIES, next state IDLE.
- Priority within a cycle: restart > ent > tick-timeout > go. restart in ENTER aborts to IDLE without consuming a try.
- timer_bcd never underflows below 8'h00. tries_left never underflows.

## Timing
- Input edge to state change: 1 clk, counted from the rising clk edge that samples the input high.
- Entry of the final digit to unlocked/locked_out asserting: 2 clks (ENTER→CHECK→OPEN/LOCKOUT).
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- RST_n low mid-operation forces reset values asynchronously. Release is synchronous to the next clk edge.
- A tick coinciding with the CHECK cycle is ignored.

## Test plan
All cases use defaults unless noted.
- Correct code: reset, go, then enter 1,3,5,7 → CHECK one cycle, then unlocked=1, state_led=6'b001000, tries_left=3; restart → IDLE.
- Wrong digit: go, enter 1,3,5,8 → FAIL, tries_left=2, unlocked=0; repeat twice more → after the third failure locked_out=1, timer_bcd=8'h10.
- Lockout expiry: in LOCKOUT apply 10 ticks with go/restart/ent pulses between them → edges are ignored; timer counts 10,09,…,01; on the 10th tick the state is IDLE, timer_bcd=8'h00, tries_left=3.
- Timeout: go, enter 1,3, then 30 ticks → on the 30th tick the state is FAIL and tries_left=2. BCD sequence checked across the 30→29 and 10→09 borrows.
- Simultaneous events: at timer_bcd=8'h01, present the last correct digit's ent edge in the same cycle as a tick → OPEN, no timeout. restart together with ent in ENTER → IDLE, tries_left unchanged.
- Reset mid-entry and held input: assert RST_n low after two digits while ent is held high, then release → all outputs at reset values, and no spurious ent edge is detected. NUM_DIGITS=1, COMBO=4'h9: go, enter 9 → OPEN.
